alu_issue_ctrl: RTL and testbench

- Upstream issue stage for the floating-point `alu`.
- Buffers operand requests {A, B, OPERATIONCODE} arriving over a valid/ready handshake and drives one operation at a time into the ALU.
- Holds the operands stable for the ALU's fixed latency, then captures `O` and presents it downstream over a valid/ready handshake.
- Converts the ALU's free-running interface into a flow-controlled stream for the sequencer and writeback logic.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_req_fifo.sv | 56 +++++
 rtl/alu_issue_ctrl.sv | 143 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, IEEE-754 single field layout,
// issue FSM states and a result-class decoder.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int FRAC_W   = 23;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // {nan, inf, zero, denormal}; sign is ignored so +/-0 both report zero
  function automatic logic [3:0] fp_flags(input logic [31:0] v);
    logic [EXP_MSB-EXP_LSB:0] e;
    logic [FRAC_W-1:0]        f;
    e = v[EXP_MSB:EXP_LSB];
    f = v[FRAC_W-1:0];
    fp_flags = {(&e) && (|f), (&e) && !(|f), !(|e) && !(|f), !(|e) && (|f)};
  endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// Synchronous request FIFO; head is visible combinationally, one cycle push-to-pop.
// Pushes while full and pops while empty are ignored; caller gates push with !full.
module alu_req_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 67
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DW-1:0]            push_dat,
  input  logic                     pop,
  output logic [DW-1:0]            pop_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CNT_MAX);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap for free
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue stage for the fp alu: queues requests, holds operands ALU_LAT cycles, then presents O
// downstream; result held until out_ready. Optional result-class flags under ALU_ISSUE_FLAGS_EN.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 2,
  parameter int W       = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_a,
  input  logic [W-1:0]           in_b,
  input  logic [2:0]             in_op,
  output logic [W-1:0]           alu_a,
  output logic [W-1:0]           alu_b,
  output logic [2:0]             alu_op,
  input  logic [W-1:0]           alu_o,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           out_result,
  output logic [2:0]             out_op,
`ifdef ALU_ISSUE_FLAGS_EN
  output logic [3:0]             out_flags,
`endif
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int CW = $clog2(ALU_LAT + 1);
  localparam logic [CW-1:0] LAT     = CW'(ALU_LAT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] b;
    logic [W-1:0] a;
  } req_t;

  req_t          push_req;
  req_t          head_req;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          capture;
  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;

  assign push_req = '{op: in_op, b: in_b, a: in_a};
  assign in_ready = !fifo_full;
  assign busy     = !fifo_empty || (state != ST_IDLE);

  alu_req_fifo #(
    .DEPTH (DEPTH),
    .DW    ($bits(req_t))
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (in_valid && in_ready),
    .push_dat (push_req),
    .pop      (pop),
    .pop_dat  (head_req),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    capture = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt == CNT_ONE) begin
          capture = 1'b1;
          state_n = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // a waiting request issues on the same edge the result is taken
        if (out_ready) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_n = ST_WAIT;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= 3'b000;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_op     <= 3'b000;
    end else begin
      state <= state_n;
      if (pop) begin
        alu_a  <= head_req.a;
        alu_b  <= head_req.b;
        alu_op <= head_req.op;
        cnt    <= LAT;
      end else if (state == ST_WAIT) begin
        cnt <= cnt - CNT_ONE;
      end
      if (capture) begin
        out_result <= alu_o;
        out_op     <= alu_op;
        out_valid  <= 1'b1;
      end else if (state == ST_HOLD && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_ISSUE_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_flags <= 4'b0000;
    end else if (capture) begin
      out_flags <= fp_flags(alu_o[31:0]);
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: request-queue scoreboard checked every cycle plus directed scenarios.
// Covers latency, backpressure, full-with-pop, throughput, mid-operation reset and optional flags.
module tb_alu_issue_ctrl;

  localparam int DEPTH   = 4;
  localparam int ALU_LAT = 2;
  localparam int W       = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [2:0]    in_op = '0;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [2:0]    alu_op;
  logic [W-1:0]  alu_o;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_result;
  logic [2:0]    out_op;
  logic          busy;
  logic [2:0]    fifo_count;
`ifdef ALU_ISSUE_FLAGS_EN
  logic [3:0]    out_flags;
`endif

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_o      (alu_o),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_op     (out_op),
`ifdef ALU_ISSUE_FLAGS_EN
    .out_flags  (out_flags),
`endif
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  // Stand-in alu: the SUB vector gives its true IEEE result, op 111 returns B verbatim,
  // anything else a scrambled but deterministic value. ALU_LAT-1 register stages.
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    if (op == 3'b001 && a == 32'h3E92E21E && b == 32'hC5D98D58) return 32'h45D98FA4;
    if (op == 3'b111) return b;
    return (a ^ {b[15:0], b[31:16]}) + {29'd0, op};
  endfunction

  function automatic logic [3:0] class_of(input logic [31:0] v);
    int unsigned e;
    int unsigned f;
    e = v[30:23];
    f = v[22:0];
    return {e == 255 && f != 0, e == 255 && f == 0, e == 0 && f == 0, e == 0 && f != 0};
  endfunction

  logic [31:0] alu_stage;
  always @(posedge clk) alu_stage <= alu_f(alu_a, alu_b, alu_op);
  assign alu_o = alu_stage;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Scoreboard: every accepted-but-undelivered request, oldest first
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] res;
  } txn_t;

  txn_t        q[$];
  int          dcyc[$];
  bit          chk_en = 1'b0;
  bit          held = 1'b0;
  logic [31:0] prev_res;
  logic [2:0]  prev_op;

  always @(negedge clk) begin
    if (chk_en) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out_valid", out_valid, 1'b0);
        end else begin
          check("sb_result", out_result, q[0].res);
          check("sb_op", out_op, q[0].op);
          check("sb_alu_a_held", alu_a, q[0].a);
          check("sb_alu_b_held", alu_b, q[0].b);
`ifdef ALU_ISSUE_FLAGS_EN
          check("sb_flags", out_flags, class_of(q[0].res));
`endif
        end
      end
      if (held) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_result_stable", out_result, prev_res);
        check("hold_op_stable", out_op, prev_op);
      end
      check("sb_busy", busy, q.size() != 0);
      check("in_ready_rule", in_ready, fifo_count != DEPTH);

      // account for what the coming edge does
      held     = out_valid && !out_ready && !rst;
      prev_res = out_result;
      prev_op  = out_op;
      if (rst) begin
        q.delete();
      end else begin
        if (out_valid && out_ready && q.size() > 0) begin
          void'(q.pop_front());
          dcyc.push_back(cyc);
        end
        if (in_valid && in_ready)
          q.push_back('{a: in_a, b: in_b, op: in_op, res: alu_f(in_a, in_b, in_op)});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns just after the accepting edge
  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    bit ok;
    ok = 1'b0;
    in_a = a;
    in_b = b;
    in_op = op;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("push_timeout", 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
  endtask

  // Edges from the previous accept until out_valid is seen; ends at that negedge
  task automatic wait_valid(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) return;
      @(posedge clk);
      n++;
    end
    check("valid_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy && !out_valid) return;
    end
    check("idle_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    int n;
    int d0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_fifo_count", fifo_count, 3'd0);
    check("rst_alu_a", alu_a, 32'h0);
    check("rst_alu_b", alu_b, 32'h0);
    check("rst_alu_op", alu_op, 3'b000);
    check("rst_out_result", out_result, 32'h0);
    check("rst_out_op", out_op, 3'b000);
    chk_en = 1'b1;

    // single SUB: result ALU_LAT+1 edges after accept
    step();
    out_ready = 1'b1;
    push(32'h3E92E21E, 32'hC5D98D58, 3'b001);
    wait_valid(n);
    check("sub_latency", n, 32'd3);
    check("sub_result", out_result, 32'h45D98FA4);
    check("sub_op", out_op, 3'b001);
    @(negedge clk);
    check("sub_busy_after", busy, 1'b0);
    check("sub_valid_after", out_valid, 1'b0);

    // backpressure: 4 queued + 1 in flight
    step();
    out_ready = 1'b0;
    d0 = dcyc.size();
    for (int i = 0; i < 5; i++)
      push(32'h1000_0000 + i, 32'h0000_0100 * (i + 1), 3'(i));
    @(negedge clk);
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_fifo_count", fifo_count, 3'd4);
    repeat (4) step();

    // full + simultaneous pop: no push this edge, accepted on the next
    in_a = 32'hCAFE_0006;
    in_b = 32'h0000_0600;
    in_op = 3'b101;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("fp_pre_count", fifo_count, 3'd4);
    check("fp_pre_ready", in_ready, 1'b0);
    step();
    @(negedge clk);
    check("fp_count_after_pop", fifo_count, 3'd3);
    check("fp_ready_after_pop", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("fp_count_after_push", fifo_count, 3'd4);
    wait_idle();
    check("bp_delivered", dcyc.size() - d0, 32'd6);

    // back-to-back throughput: one result per ALU_LAT+1 cycles
    step();
    d0 = dcyc.size();
    push(32'h0000_00A1, 32'h0000_00B1, 3'b010);
    push(32'h0000_00A2, 32'h0000_00B2, 3'b011);
    push(32'h0000_00A3, 32'h0000_00B3, 3'b100);
    wait_idle();
    check("tp_count", dcyc.size() - d0, 32'd3);
    if (dcyc.size() - d0 == 3) begin
      check("tp_gap1", dcyc[d0+1] - dcyc[d0], 32'd3);
      check("tp_gap2", dcyc[d0+2] - dcyc[d0+1], 32'd3);
    end

    // reset on the edge where cnt==1 discards everything
    step();
    push(32'h1111_1111, 32'h2222_2222, 3'b001);
    push(32'h3333_3333, 32'h4444_4444, 3'b110);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_fifo_count", fifo_count, 3'd0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("mid_rst_no_stale", out_valid, 1'b0);
    end

`ifdef ALU_ISSUE_FLAGS_EN
    step();
    push(32'h0, 32'h7FC00000, 3'b111);
    wait_valid(n);
    check("flags_nan", out_flags, 4'b1000);
    step();
    push(32'h0, 32'h00000000, 3'b111);
    wait_valid(n);
    check("flags_zero", out_flags, 4'b0010);
    step();
    push(32'h0, 32'h00000001, 3'b111);
    wait_valid(n);
    check("flags_denormal", out_flags, 4'b0001);
    wait_idle();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    errors++;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
